// File: rtl/gt_sys_bus.sv
// ---------------------------------------------------------------------------
// gt_sys_bus -- 8-bit CPU system bus decoder with work RAM, a small I/O
// register block and a ROM read port that stalls the CPU via bus_wait.
//
// Address map (AB):
//   $0000-$1FFF  work RAM, 2^WRAM_AW bytes, mirrored through the window
//   $2000-$2007  I/O: SCRATCH, STATUS, TIMER_LO, TIMER_HI, four reserved
//   $2008-$7FFF  unmapped (writes dropped, reads leave DB_IN as it was)
//   $8000-$FFFF  ROM, fetched through the rom_req/rom_ack port
//
// Ports:
//   Clk, nRst        clock, asynchronous active-low reset
//   AB, DB           CPU address and write data
//   nRD, nWR         CPU strobes (active low), sampled on the rising edge
//   DB_IN            registered read data back to the CPU
//   bus_wait         high while a ROM read is outstanding
//   rom_addr         ROM byte address, held from request until completion
//   rom_req          ROM read request
//   rom_ack          ROM data valid this cycle
//   rom_data         ROM read data
//   bus_err          sticky error flag (STATUS[1])
//   dbg_rom_state_o  current ROM FSM state (0 IDLE, 1 WAIT, 2 DONE)
//
// ROM handshake: rom_req is a level that rises on the edge the CPU read is
// accepted and stays high until the first edge on which rom_ack is sampled
// high while the FSM is in WAIT; that edge transfers rom_data and drops
// rom_req. rom_ack at any other time carries no meaning and is ignored. If no
// rom_ack arrives within ROM_TIMEOUT wait cycles the read completes with $FF
// and bus_err is set.
// ---------------------------------------------------------------------------
module gt_sys_bus #(
    parameter int WRAM_AW     = 11,
    parameter int ROM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        nRst,
    input  logic [15:0] AB,
    input  logic [7:0]  DB,
    input  logic        nRD,
    input  logic        nWR,
    output logic [7:0]  DB_IN,
    output logic        bus_wait,
    output logic [14:0] rom_addr,
    output logic        rom_req,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic        bus_err,
    output logic [1:0]  dbg_rom_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } rom_state_e;

    localparam int CNT_W = (ROM_TIMEOUT < 2) ? 1 : $clog2(ROM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_TIMEOUT - 1);

    // I/O register offsets within $2000-$2007
    localparam logic [2:0] IO_SCRATCH  = 3'd0;
    localparam logic [2:0] IO_STATUS   = 3'd1;
    localparam logic [2:0] IO_TIMER_LO = 3'd2;
    localparam logic [2:0] IO_TIMER_HI = 3'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]  wram [2**WRAM_AW];

    rom_state_e  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]  db_in_q;
    logic        bus_wait_q;
    logic        rom_req_q;
    logic [14:0] rom_addr_q;
    logic        bus_err_q;
    logic [7:0]  scratch_q;
    logic [15:0] timer_q;
    logic [7:0]  timer_hi_q;

    // ------------------------------------------------------------------
    // Strobe qualification and address decode
    // ------------------------------------------------------------------
    logic idle;
    logic cyc_rd;
    logic cyc_wr;
    logic cyc_conflict;
    logic sel_wram;
    logic sel_io;
    logic sel_rom;
    logic [WRAM_AW-1:0] wram_idx;
    logic [7:0] io_rdata;
    logic rom_busy;

    assign idle         = (state_q == ST_IDLE);
    assign cyc_rd       = idle && !nRD &&  nWR;
    assign cyc_wr       = idle &&  nRD && !nWR;
    // Both strobes low is a CPU fault: no access, just flag it.
    assign cyc_conflict = idle && !nRD && !nWR;

    assign sel_wram = (AB[15:13] == 3'b000);
    assign sel_io   = (AB[15:3]  == 13'h0400);
    assign sel_rom  = AB[15];
    assign wram_idx = AB[WRAM_AW-1:0];
    assign rom_busy = !idle;

    always_comb begin
        io_rdata = 8'h00;
        case (AB[2:0])
            IO_SCRATCH:  io_rdata = scratch_q;
            IO_STATUS:   io_rdata = {6'b0, bus_err_q, rom_busy};
            IO_TIMER_LO: io_rdata = timer_q[7:0];
            IO_TIMER_HI: io_rdata = timer_hi_q;
            default:     io_rdata = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Work RAM. Not reset: contents survive nRst. A read issued the edge
    // after a write sees the new byte because the array is already updated.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (cyc_wr && sel_wram) begin
            wram[wram_idx] <= DB;
        end
    end

    // ------------------------------------------------------------------
    // Bus control, I/O registers, timer and ROM FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            db_in_q    <= 8'h00;
            bus_wait_q <= 1'b0;
            rom_req_q  <= 1'b0;
            rom_addr_q <= 15'h0000;
            bus_err_q  <= 1'b0;
            scratch_q  <= 8'h00;
            timer_q    <= 16'h0000;
            timer_hi_q <= 8'h00;
        end else begin
            timer_q <= timer_q + 16'd1;

            case (state_q)
                ST_IDLE: begin
                    if (cyc_conflict) begin
                        bus_err_q <= 1'b1;
                    end else if (cyc_rd) begin
                        if (sel_wram) begin
                            db_in_q <= wram[wram_idx];
                        end else if (sel_io) begin
                            db_in_q <= io_rdata;
                            // Snapshot the high byte so a later TIMER_HI read
                            // pairs coherently with this low byte.
                            if (AB[2:0] == IO_TIMER_LO) begin
                                timer_hi_q <= timer_q[15:8];
                            end
                        end else if (sel_rom) begin
                            rom_addr_q <= AB[14:0];
                            rom_req_q  <= 1'b1;
                            bus_wait_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= ST_WAIT;
                        end
                        // unmapped read: open bus, DB_IN holds
                    end else if (cyc_wr && sel_io) begin
                        if (AB[2:0] == IO_SCRATCH) begin
                            scratch_q <= DB;
                        end else if (AB[2:0] == IO_STATUS) begin
                            bus_err_q <= 1'b0;
                        end
                    end
                end

                ST_WAIT: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (rom_ack) begin
                        db_in_q   <= rom_data;
                        rom_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        db_in_q   <= 8'hFF;
                        bus_err_q <= 1'b1;
                        rom_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    bus_wait_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end

                default: begin
                    rom_req_q  <= 1'b0;
                    bus_wait_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign DB_IN           = db_in_q;
    assign bus_wait        = bus_wait_q;
    assign rom_req         = rom_req_q;
    assign rom_addr        = rom_addr_q;
    assign bus_err         = bus_err_q;
    assign dbg_rom_state_o = state_q;

endmodule
